uart_core_param: RTL and testbench
==================================

# uart_core_param

Parametrised full-duplex UART core: one transmitter and one 16x-oversampled receiver, configurable in data width, baud divisor, parity mode and stop-bit count. Generalises the fixed 8-bit lab UART with a valid/ready transmit handshake, a false-start-rejecting receiver, and parity/framing error flags. Sits between the board-level top (switches, buttons, LEDs) and the serial pins `Tx`/`Rx`.

## Interface
- `DATA_BITS`, 8: payload width, 5..9, LSB sent first
- `CLK_DIV`, 4: clocks per oversample tick, ≥2; one bit lasts 16·CLK_DIV clocks
- `PARITY_MODE`, 2: 0 none, 1 odd, 2 even
- `STOP_BITS`, 1: 1 or 2

- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `tx_data`  in  DATA_BITS  byte to send, sampled on accept
- `tx_valid`  in  1  request to send
- `tx_ready`  out  1  transmitter idle; accept = tx_valid & tx_ready
- `Tx`  out  1  serial output, idle high
- `Rx`  in  1  serial input, asynchronous
- `rx_data`  out  DATA_BITS  last received word, held until the next one
- `rx_valid`  out  1  one-cycle pulse: new rx_data
- `rx_parity_err`  out  1  qualified by rx_valid
- `rx_frame_err`  out  1  qualified by rx_valid; first stop bit sampled low
- `slowclock`  out  1  oversample tick, one-cycle pulse every CLK_DIV clocks

## Operation
- Tick generator: counter 0..CLK_DIV-1, `slowclock`=1 in the cycle the counter equals CLK_DIV-1; free-running, used by RX only.
- TX FSM: IDLE → START → DATA → PARITY (skipped if PARITY_MODE=0) → STOP → IDLE. Own clock counter per bit, cleared on accept; each bit holds exactly 16·CLK_DIV clocks. Odd parity: XOR of data ^ 1; even: XOR of data. STOP lasts STOP_BITS bit periods. `tx_ready`=1 only in IDLE. tx_valid while busy is ignored, not queued.
- RX: `Rx` passes a 2-flop synchroniser. FSM IDLE → START → DATA → PARITY (skipped if none) → STOP → IDLE, advancing on ticks. IDLE: synchronised low moves to START with tick count cleared. START: at tick 7 sample; high → IDLE (false start, no pulse); low → DATA. Each later bit sampled 16 ticks after the previous sample. Only the first stop bit is checked; RX returns to IDLE after sampling it (the second stop bit is not required by RX).
- At the stop sample: rx_data, rx_parity_err, rx_frame_err update and rx_valid pulses for one cycle, regardless of error. rx_parity_err=0 when PARITY_MODE=0.
- No RX backpressure; an unread word is overwritten by the next.

## Timing
- Reset values: Tx=1, tx_ready=1, rx_valid=0, rx_data=0, both error flags 0, slowclock=0, both FSMs IDLE, tick counter 0.
- Accept in cycle N → Tx=0 from cycle N+1; frame length (1+DATA_BITS+P+STOP_BITS)·16·CLK_DIV clocks; tx_ready=1 again at N+1+frame length, back-to-back accept allowed that cycle.
- RX latency: falling edge reaches FSM 2 clocks later; tick phase adds 0..CLK_DIV-1 clocks uncertainty; rx_valid ≈ middle of first stop bit.
- rst asserted mid-frame: Tx=1 and tx_ready=1 the next cycle; RX frame discarded, no rx_valid.
- `Rx` held low (break): START→DATA proceeds, frame_err=1 at stop sample, then RX waits in IDLE for high before re-arming on a new falling edge.

## Structure
- Shared package `uart_pkg`: parity-mode constants (PAR_NONE/ODD/EVEN), TX and RX state encodings, OVERSAMPLE=16, mid-bit sample index 7.
- Sub-module `uart_baud_tick` (divider producing `slowclock`); TX and RX FSMs stay in this module.

## Test plan
- Reset: rst=1 two cycles → Tx=1, tx_ready=1, rx_valid=0, rx_data=0.
- TX 0xC6, DATA_BITS=8, CLK_DIV=4, even parity, 1 stop → Tx: 0, 0,1,1,0,0,0,1,1, parity 0, 1; 64 clocks per bit; tx_ready high 704 clocks after accept.
- Loopback Tx→Rx, same config, send 0xC6 then 0x35 back-to-back → two rx_valid pulses, rx_data 0xC6 then 0x35, no error flags.
- Rx low for 20 clocks then high → no rx_valid, RX back in IDLE; next valid frame 0xA5 received correctly.
- Driven frame 0x0F with parity bit 1 (even mode) → rx_valid, rx_data=0x0F, rx_parity_err=1; frame with stop=0 → rx_frame_err=1.
- rst pulse at bit 4 of a TX frame → Tx=1 next cycle, tx_ready=1, new accept sends a clean frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the parametrised UART core.
// Holds parity-mode codes, the oversampling ratio, the mid-bit sample index
// and the state encodings of the transmit and receive FSMs.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing the receiver oversample tick.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (counter back to 0)
//   tick - one-cycle pulse while the counter equals CLK_DIV-1
module uart_baud_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_core_param.sv
// uart_core_param: full-duplex UART, one transmitter plus a 16x-oversampled
// receiver with false-start rejection and parity/framing error flags.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   tx_data/valid   - word to send; accepted when tx_valid & tx_ready
//   tx_ready        - transmitter idle
//   Tx              - serial output, idle high
//   Rx              - asynchronous serial input
//   rx_data         - last received word, held until the next one
//   rx_valid        - one-cycle pulse when rx_data/error flags update
//   rx_parity_err   - parity mismatch, qualified by rx_valid
//   rx_frame_err    - first stop bit sampled low, qualified by rx_valid
//   slowclock       - oversample tick (one pulse every CLK_DIV clocks)
module uart_core_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int CLK_DIV     = 4,
    parameter int PARITY_MODE = 2,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 Tx,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 slowclock
);

    localparam int  BIT_CLKS  = OVERSAMPLE * CLK_DIV;
    localparam int  CW        = $clog2(BIT_CLKS);
    localparam bit  HAS_PAR   = (PARITY_MODE != PAR_NONE);
    localparam bit  ODD_PAR   = (PARITY_MODE == PAR_ODD);

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (slowclock)
    );

    // ---------------- transmitter ----------------
    logic [2:0]           tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic [3:0]           tx_bit;
    logic                 tx_par;
    logic                 tx_stop_idx;
    logic                 tx_line;
    logic                 tx_bit_end;

    assign tx_ready   = (tx_state == TX_IDLE);
    assign Tx         = tx_line;
    assign tx_bit_end = (tx_cnt == CW'(BIT_CLKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx_line     <= 1'b1;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_stop_idx <= 1'b0;
        end else begin
            // Per-bit clock counter runs only while a frame is in flight.
            if (tx_state != TX_IDLE) begin
                tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
            end
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        tx_state <= TX_START;
                        tx_line  <= 1'b0;
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_shift <= tx_data;
                        tx_par   <= (^tx_data) ^ ODD_PAR;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_DATA;
                        tx_line  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit == 4'(DATA_BITS - 1)) begin
                            tx_stop_idx <= 1'b0;
                            if (HAS_PAR) begin
                                tx_state <= TX_PARITY;
                                tx_line  <= tx_par;
                            end else begin
                                tx_state <= TX_STOP;
                                tx_line  <= 1'b1;
                            end
                        end else begin
                            tx_line  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_state <= TX_STOP;
                        tx_line  <= 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        if (STOP_BITS == 1 || tx_stop_idx) begin
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_line  <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic                 rx_meta;
    logic                 rx_sync;
    logic [2:0]           rx_state;
    logic [3:0]           rx_tick_cnt;
    logic [3:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_bit;
    logic                 rx_armed;
    logic                 rx_at_sample;
    logic                 rx_sample;

    // START samples at mid-bit; every later bit is one full bit (16 ticks) on.
    assign rx_at_sample = (rx_state == RX_START) ? (rx_tick_cnt == 4'(MID_SAMPLE))
                                                 : (rx_tick_cnt == 4'(OVERSAMPLE - 1));
    assign rx_sample    = slowclock && rx_at_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_tick_cnt   <= '0;
            rx_bit        <= '0;
            rx_armed      <= 1'b0;
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_meta  <= Rx;
            rx_sync  <= rx_meta;
            rx_valid <= 1'b0;
            if (rx_state != RX_IDLE && slowclock) begin
                rx_tick_cnt <= rx_at_sample ? '0 : rx_tick_cnt + 1'b1;
            end
            case (rx_state)
                RX_IDLE: begin
                    // Only a high-to-low transition starts a frame, so a held
                    // break line must go high again before re-arming.
                    if (rx_sync) begin
                        rx_armed <= 1'b1;
                    end else if (rx_armed) begin
                        rx_state    <= RX_START;
                        rx_tick_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (rx_sample) begin
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_sample) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == 4'(DATA_BITS - 1)) begin
                            rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_sample) begin
                        rx_par_bit <= rx_sync;
                        rx_state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_sample) begin
                        rx_data       <= rx_shift;
                        rx_parity_err <= HAS_PAR && (((^rx_shift) ^ rx_par_bit) != ODD_PAR);
                        rx_frame_err  <= ~rx_sync;
                        rx_valid      <= 1'b1;
                        rx_armed      <= 1'b0;
                        rx_state      <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core_param.sv
// Scoreboard bench for uart_core_param (8 data bits, CLK_DIV=4, even parity,
// one stop bit). Receive expectations are queued by the stimulus and popped
// by an independent monitor on every rx_valid pulse.
module tb_uart_core_param;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       Tx;
    logic       Rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       slowclock;

    logic       loopback;
    logic       rx_drv;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    assign Rx = loopback ? Tx : rx_drv;

    uart_core_param #(
        .DATA_BITS   (8),
        .CLK_DIV     (4),
        .PARITY_MODE (2),
        .STOP_BITS   (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .Tx            (Tx),
        .Rx            (Rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .slowclock     (slowclock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!tx_ready && k < 2000) begin
            step(1);
            k++;
        end
        if (k >= 2000) check("tx_ready_timeout", 32'(tx_ready), 32'd1);
    endtask

    task automatic accept(input logic [7:0] d);
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
    endtask

    // bits[0] is the start bit, bits[10] the stop bit.
    task automatic tx_frame_check(input logic [7:0] d, input logic [10:0] bits, input string tag);
        accept(d);
        for (int j = 0; j < 704; j++) begin
            if (j % 64 == 32) check($sformatf("%s_tx_bit%0d", tag, j / 64), 32'(Tx), 32'(bits[j / 64]));
            if (j == 703) check($sformatf("%s_ready_low_703", tag), 32'(tx_ready), 32'd0);
            step(1);
        end
        check($sformatf("%s_ready_704", tag), 32'(tx_ready), 32'd1);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic p, input logic s);
        rx_drv = 1'b0;
        step(64);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            step(64);
        end
        rx_drv = p;
        step(64);
        rx_drv = s;
        step(64);
        rx_drv = 1'b1;
        step(128);
    endtask

    task automatic wait_drained(input string tag);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 3000) begin
            step(1);
            k++;
        end
        check($sformatf("%s_pending", tag), 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every rx_valid pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rx_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rx_unexpected: got rx_valid with data %0h, expected no pulse", rx_data);
                end else begin
                    e = sb.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.d));
                    check("rx_parity_err", 32'(rx_parity_err), 32'(e.pe));
                    check("rx_frame_err", 32'(rx_frame_err), 32'(e.fe));
                end
            end
        end
    end

    initial begin
        int ticks;
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        loopback = 1'b0;
        rx_drv   = 1'b1;

        // Reset state
        step(2);
        check("rst_Tx", 32'(Tx), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_parity_err", 32'(rx_parity_err), 32'd0);
        check("rst_frame_err", 32'(rx_frame_err), 32'd0);
        check("rst_slowclock", 32'(slowclock), 32'd0);
        rst = 1'b0;
        step(4);

        // Tick rate: 40 clocks hold exactly 10 pulses at CLK_DIV=4
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            if (slowclock) ticks++;
            step(1);
        end
        check("slowclock_count", 32'(ticks), 32'd10);

        // TX waveform of 0xC6: 0 | 0,1,1,0,0,0,1,1 | parity 0 | stop 1
        tx_frame_check(8'hC6, 11'b10110001100, "c6");
        step(10);

        // Loopback, back-to-back frames
        loopback = 1'b1;
        step(10);
        sb.push_back('{d: 8'hC6, pe: 1'b0, fe: 1'b0});
        sb.push_back('{d: 8'h35, pe: 1'b0, fe: 1'b0});
        accept(8'hC6);
        accept(8'h35);
        wait_drained("loopback");
        wait_ready();
        step(100);
        loopback = 1'b0;
        step(100);

        // False start: 20 clocks low, no pulse expected, then a good frame
        rx_drv = 1'b0;
        step(20);
        rx_drv = 1'b1;
        step(200);
        check("false_start_pending", 32'(sb.size()), 32'd0);
        sb.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
        drive_frame(8'hA5, 1'b0, 1'b1);
        wait_drained("a5");

        // Parity error: 0x0F has even popcount, so a parity bit of 1 is wrong
        sb.push_back('{d: 8'h0F, pe: 1'b1, fe: 1'b0});
        drive_frame(8'h0F, 1'b1, 1'b1);
        wait_drained("parity");

        // Framing error: stop bit driven low
        sb.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b1});
        drive_frame(8'h3C, 1'b0, 1'b0);
        wait_drained("frame");

        // Good frame after the framing error re-arms correctly
        sb.push_back('{d: 8'h81, pe: 1'b0, fe: 1'b0});
        drive_frame(8'h81, 1'b0, 1'b1);
        wait_drained("after_frame");

        // Reset during bit 4 of a TX frame, then a clean frame
        accept(8'h5A);
        step(4 * 64 + 20);
        check("midframe_busy", 32'(tx_ready), 32'd0);
        rst = 1'b1;
        step(1);
        check("midrst_Tx", 32'(Tx), 32'd1);
        check("midrst_tx_ready", 32'(tx_ready), 32'd1);
        rst = 1'b0;
        step(3);
        tx_frame_check(8'h5A, 11'b10010110100, "5a");

        step(200);
        check("final_pending", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
